// File: rtl/cube_face_loader.sv
// Chunked loader that assembles NUM_FACES cube face colour words into one state vector
// for the solver core, with frame delimiting, short/long frame detection and resync.
module cube_face_loader #(
    parameter int NUM_FACES = 3,
    parameter int FACE_W    = 24,
    parameter int IN_W      = 8,
    localparam int CHUNKS   = NUM_FACES * FACE_W / IN_W,
    localparam int CW       = $clog2(CHUNKS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [NUM_FACES*FACE_W-1:0]   state_data,
    output logic                          state_valid,
    input  logic                          state_ready,
    output logic                          frame_err,
    output logic [CW-1:0]                 chunk_cnt,
    output logic [1:0]                    fsm_state
);

    localparam int SLOTS = FACE_W / IN_W;
    localparam logic [CW-1:0] LAST_IDX = CW'(CHUNKS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CHUNKS);

    if (FACE_W % IN_W != 0) begin : g_bad_chunk_width
        $error("cube_face_loader: FACE_W must be a multiple of IN_W");
    end

    // Handshakes: a chunk moves on a rising edge where in_valid && in_ready;
    // the assembled state is consumed on a rising edge where state_valid && state_ready.
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RESYNC  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt_next;
    logic          err_next;
    logic          write_en;
    logic          xfer;

    // Low bit of chunk k's slot: slot 0 holds the face MSBs.
    function automatic int slot_lo(input int k);
        return (k / SLOTS) * FACE_W + FACE_W - ((k % SLOTS) + 1) * IN_W;
    endfunction

    // Outputs decode straight from the state register, so no input reaches them combinationally.
    assign in_ready    = (state != PRESENT);
    assign state_valid = (state == PRESENT);
    assign fsm_state   = state;
    assign xfer        = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            chunk_cnt <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            chunk_cnt <= cnt_next;
            frame_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = chunk_cnt;
        err_next   = 1'b0;
        write_en   = 1'b0;
        case (state)
            LOAD: begin
                if (xfer) begin
                    write_en = 1'b1;
                    if (chunk_cnt == LAST_IDX) begin
                        if (in_last) begin
                            state_next = PRESENT;
                            cnt_next   = FULL_CNT;
                        end else begin
                            // Long frame: drop everything up to the next in_last.
                            state_next = RESYNC;
                            cnt_next   = '0;
                            err_next   = 1'b1;
                        end
                    end else if (in_last) begin
                        cnt_next = '0;
                        err_next = 1'b1;
                    end else begin
                        cnt_next = chunk_cnt + CW'(1);
                    end
                end
            end
            RESYNC: begin
                if (xfer && in_last) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            PRESENT: begin
                if (state_ready) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = LOAD;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_data <= '0;
        end else if (write_en) begin
            for (int k = 0; k < CHUNKS; k++) begin
                if (chunk_cnt == CW'(k)) begin
                    state_data[slot_lo(k) +: IN_W] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_cube_face_loader.sv
// Directed bench for cube_face_loader: vector table for framing behaviour plus
// hand-written sequences for backpressure, reset and a wider parameter set.
module tb_cube_face_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [71:0] state_data;
  logic        state_valid;
  logic        state_ready;
  logic        frame_err;
  logic [3:0]  chunk_cnt;
  logic [1:0]  fsm_state;

  logic [8:0]   p_in_data;
  logic         p_in_valid;
  logic         p_in_last;
  logic         p_in_ready;
  logic [161:0] p_state_data;
  logic         p_state_valid;
  logic         p_state_ready;
  logic         p_frame_err;
  logic [4:0]   p_chunk_cnt;
  logic [1:0]   p_fsm_state;

  int n_checks;
  int n_fail;

  cube_face_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .state_data(state_data), .state_valid(state_valid),
    .state_ready(state_ready), .frame_err(frame_err), .chunk_cnt(chunk_cnt),
    .fsm_state(fsm_state)
  );

  cube_face_loader #(.NUM_FACES(6), .FACE_W(27), .IN_W(9)) dut6 (
    .clk(clk), .rst(rst), .in_data(p_in_data), .in_valid(p_in_valid), .in_last(p_in_last),
    .in_ready(p_in_ready), .state_data(p_state_data), .state_valid(p_state_valid),
    .state_ready(p_state_ready), .frame_err(p_frame_err), .chunk_cnt(p_chunk_cnt),
    .fsm_state(p_fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        l;
    logic        sr;
    logic        e_rdy;
    logic        e_vld;
    logic        e_err;
    logic [3:0]  e_cnt;
    logic [1:0]  e_st;
    logic        chk_d;
    logic [71:0] e_data;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic v, input logic l, input logic sr,
                     input logic r, input logic vl, input logic e, input logic [3:0] c,
                     input logic [1:0] st, input logic chk, input logic [71:0] dat);
    vec_t t;
    t.d = d; t.v = v; t.l = l; t.sr = sr;
    t.e_rdy = r; t.e_vld = vl; t.e_err = e; t.e_cnt = c; t.e_st = st;
    t.chk_d = chk; t.e_data = dat;
    tab.push_back(t);
  endtask

  // Good 9-chunk frame followed by one consume cycle; state_ready is raised mid-frame
  // to show it is ignored while loading.
  task automatic add_frame(input logic [7:0] base, input logic [7:0] stp, input logic [71:0] dat);
    logic [7:0] d;
    for (int k = 0; k < 9; k++) begin
      d = base + stp * 8'(k);
      add(d, 1'b1, k == 8, k == 3, k != 8, k == 8, 1'b0, 4'(k + 1),
          (k == 8) ? 2'd2 : 2'd0, k == 8, dat);
    end
    add(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, dat);
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic l, input logic sr);
    in_data = d; in_valid = v; in_last = l; state_ready = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int k = 0; k < 9; k++) step(base + 8'(k), 1'b1, k == 8, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 192'(in_ready), 192'(1));
    check({tag, "_state_valid"}, 192'(state_valid), 192'(0));
    check({tag, "_frame_err"}, 192'(frame_err), 192'(0));
    check({tag, "_chunk_cnt"}, 192'(chunk_cnt), 192'(0));
    check({tag, "_state_data"}, 192'(state_data), 192'(0));
  endtask

  logic [8:0]   pc[18];
  logic [161:0] p_exp;

  initial begin
    n_checks = 0;
    n_fail = 0;
    in_data = '0; in_valid = 0; in_last = 0; state_ready = 0;
    p_in_data = '0; p_in_valid = 0; p_in_last = 0; p_state_ready = 0;

    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_vals("reset");
    check("reset_p_cnt", 192'(p_chunk_cnt), 192'(0));
    check("reset_p_in_ready", 192'(p_in_ready), 192'(1));
    rst = 1'b0;

    // Frame A: 0x11,0x22,...,0x99
    add_frame(8'h11, 8'h11, 72'h778899_445566_112233);
    // idle cycle: in_last without in_valid does nothing
    add(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, '0);
    // short frame, in_last on the 4th chunk
    for (int k = 0; k < 4; k++)
      add(8'hC1 + 8'(k), 1'b1, k == 3, 1'b0, 1'b1, 1'b0, k == 3, (k == 3) ? 4'd0 : 4'(k + 1),
          2'd0, 1'b0, '0);
    add(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, '0);
    add_frame(8'hA1, 8'h01, 72'hA7A8A9_A4A5A6_A1A2A3);
    // long frame: 12 chunks, in_last only on the 12th
    for (int k = 0; k < 12; k++)
      add(8'hD1 + 8'(k), 1'b1, k == 11, 1'b0, 1'b1, 1'b0, k == 8, (k < 8) ? 4'(k + 1) : 4'd0,
          (k >= 8 && k < 11) ? 2'd1 : 2'd0, 1'b0, '0);
    add_frame(8'h31, 8'h01, 72'h373839_343536_313233);

    foreach (tab[i]) begin
      step(tab[i].d, tab[i].v, tab[i].l, tab[i].sr);
      check($sformatf("vec%0d_in_ready", i), 192'(in_ready), 192'(tab[i].e_rdy));
      check($sformatf("vec%0d_state_valid", i), 192'(state_valid), 192'(tab[i].e_vld));
      check($sformatf("vec%0d_frame_err", i), 192'(frame_err), 192'(tab[i].e_err));
      check($sformatf("vec%0d_chunk_cnt", i), 192'(chunk_cnt), 192'(tab[i].e_cnt));
      check($sformatf("vec%0d_fsm_state", i), 192'(fsm_state), 192'(tab[i].e_st));
      if (tab[i].chk_d)
        check($sformatf("vec%0d_state_data", i), 192'(state_data), 192'(tab[i].e_data));
    end

    // Backpressure: 20 cycles of offered chunks while the solver stalls
    send_frame(8'h41);
    check("bp_present", 192'(state_valid), 192'(1));
    for (int c = 0; c < 20; c++) begin
      step(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check($sformatf("bp%0d_in_ready", c), 192'(in_ready), 192'(0));
      check($sformatf("bp%0d_state_valid", c), 192'(state_valid), 192'(1));
      check($sformatf("bp%0d_chunk_cnt", c), 192'(chunk_cnt), 192'(9));
      check($sformatf("bp%0d_state_data", c), 192'(state_data), 192'(72'h474849_444546_414243));
    end
    step(8'h00, 1'b0, 1'b0, 1'b1);
    check("bp_release_valid", 192'(state_valid), 192'(0));
    check("bp_release_ready", 192'(in_ready), 192'(1));
    check("bp_release_cnt", 192'(chunk_cnt), 192'(0));

    // Reset mid-frame after 5 chunks
    for (int k = 0; k < 5; k++) step(8'h51 + 8'(k), 1'b1, 1'b0, 1'b0);
    check("mid_cnt5", 192'(chunk_cnt), 192'(5));
    rst = 1'b1;
    step(8'h56, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    check_reset_vals("rst_mid");

    // Reset while presenting
    send_frame(8'h61);
    check("pre_rst_valid", 192'(state_valid), 192'(1));
    rst = 1'b1;
    step(8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check_reset_vals("rst_present");

    send_frame(8'h71);
    check("post_rst_valid", 192'(state_valid), 192'(1));
    check("post_rst_data", 192'(state_data), 192'(72'h777879_747576_717273));
    check("post_rst_cnt", 192'(chunk_cnt), 192'(9));
    step(8'h00, 1'b0, 1'b0, 1'b1);
    check("post_rst_consume", 192'(state_valid), 192'(0));

    // Six faces of 27 bits in 9-bit chunks
    for (int k = 0; k < 18; k++) pc[k] = 9'(k * 29 + 7);
    p_exp = '0;
    for (int f = 0; f < 6; f++) p_exp[f*27 +: 27] = {pc[3*f], pc[3*f+1], pc[3*f+2]};
    for (int k = 0; k < 18; k++) begin
      p_in_data = pc[k]; p_in_valid = 1'b1; p_in_last = (k == 17); p_state_ready = 1'b0;
      @(posedge clk);
      #1;
      if (k == 16) check("p_cnt17", 192'(p_chunk_cnt), 192'(17));
    end
    p_in_valid = 1'b0; p_in_last = 1'b0;
    check("p_valid", 192'(p_state_valid), 192'(1));
    check("p_cnt18", 192'(p_chunk_cnt), 192'(18));
    check("p_face5", 192'(p_state_data[161:135]), 192'({pc[15], pc[16], pc[17]}));
    check("p_data", 192'(p_state_data), 192'(p_exp));
    check("p_err", 192'(p_frame_err), 192'(0));
    check("p_state", 192'(p_fsm_state), 192'(2));
    p_state_ready = 1'b1;
    @(posedge clk);
    #1;
    p_state_ready = 1'b0;
    check("p_consume_valid", 192'(p_state_valid), 192'(0));
    check("p_consume_ready", 192'(p_in_ready), 192'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
